// File: rtl/cfs_apb_reg_slave.sv
// APB slave register bank: parametrised width/count, byte strobes, wait states,
// read-only status registers, pslverr generation and one-cycle write-commit pulses.
module cfs_apb_reg_slave #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL     = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int unsigned           NumLanes = DATA_WIDTH / 8;
  localparam int unsigned           LaneBits = $clog2(NumLanes);
  localparam logic [ADDR_WIDTH-1:0] LaneMask = ADDR_WIDTH'((1 << LaneBits) - 1);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     reg_wr_q, reg_wr_d;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [NUM_REGS-1:0]     sel_oh;
  logic                    misaligned, out_of_range, ro_write, err;
  logic                    in_access, complete;
  logic [DATA_WIDTH-1:0]   rd_val;

  // Address decode; sel_oh is all-zero when idx falls outside the bank.
  always_comb begin
    idx    = paddr >> LaneBits;
    sel_oh = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_oh[i] = (idx == ADDR_WIDTH'(i));
      if (sel_oh[i]) begin
        rd_val = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
    misaligned   = |(paddr & LaneMask);
    out_of_range = ~|sel_oh;
    ro_write     = pwrite & (|(sel_oh & RO_MASK));
    err          = misaligned | out_of_range | ro_write;
  end

  assign in_access = (state_q == StAccess);
  assign pready    = in_access && (cnt_q == 4'(WAIT_STATES));
  assign complete  = pready & psel & penable;
  assign pslverr   = pready & err;
  assign prdata    = (pready & ~pwrite & ~err) ? rd_val : '0;
  assign reg_wr    = reg_wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        // Completion and abort both return to idle; only completion commits.
        if (!psel || !penable || pready) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reg_wr_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (complete && pwrite && !err) begin
      reg_wr_d = sel_oh;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NumLanes; b++) begin
          if (sel_oh[i] && pstrb[b]) begin
            regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      reg_wr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_wr_q <= reg_wr_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
